// File: rtl/ifetch_issue_pkg.sv
// Shared types for the instruction fetch front end: FSM states, the
// per-instruction record handed to the fetch stage, and small helpers.
package ifetch_issue_pkg;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DROP,
    HALT
  } ifetch_state_t;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        misalign;
  } ifetch_out_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_issue_skid_buf.sv
// One-entry holding buffer for a fetched instruction that arrived while the
// fetch stage was stalled; the entry's valid bit doubles as the full flag.
module ifetch_skid_buf
  import ifetch_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  ifetch_out_t push_data,
  input  logic        pop,
  input  logic        flush,
  output ifetch_out_t data
);

  ifetch_out_t entry_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      entry_q <= '0;
    end else if (push) begin
      entry_q <= push_data;
    end else if (pop) begin
      entry_q <= '0;
    end
  end

  assign data = entry_q;

endmodule

// File: rtl/ifetch_issue.sv
// Fetch front end: owns the PC, issues ibus requests and presents one
// registered instruction record to the fetch stage, honouring stall and redirect.
module ifetch_issue
  import ifetch_issue_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] raw_instr,
  output logic [63:0] pc,
  output logic        instr_misalign
);

  ifetch_state_t state_q;
  logic [63:0]   pc_q;
  logic [63:0]   drop_addr_q;
  ifetch_out_t   out_q;
  ifetch_out_t   buf_data;
  ifetch_out_t   fetched;
  logic          misaligned;
  logic          slot_free;
  logic          buf_push;
  logic          buf_pop;

  assign misaligned = is_misaligned(pc_q[1:0]);
  assign slot_free  = !out_q.valid || !stall;

  // DROP keeps presenting the pre-redirect address so the bus never sees a withdrawn request
  assign ireq_valid = ((state_q == REQ) && !misaligned) || (state_q == DROP);
  assign ireq_addr  = (state_q == DROP) ? drop_addr_q : pc_q;

  assign fetched = '{valid: 1'b1, raw_instr: iresp_data, pc: pc_q, misalign: 1'b0};

  assign buf_push = !reset && !redirect_valid && (state_q == REQ) && !misaligned
                    && iresp_data_ok && !slot_free;
  assign buf_pop  = !reset && !redirect_valid && (state_q == HOLD) && slot_free;

  ifetch_skid_buf u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (buf_push),
    .push_data(fetched),
    .pop      (buf_pop),
    .flush    (redirect_valid),
    .data     (buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      out_q       <= '0;
    end else if (redirect_valid) begin
      out_q <= '0;
      pc_q  <= redirect_pc;
      if (ireq_valid && !iresp_data_ok) begin
        state_q     <= DROP;
        drop_addr_q <= ireq_addr;
      end else begin
        state_q <= REQ;
      end
    end else begin
      // A consumed record retires unless something below reloads the slot
      if (slot_free) begin
        out_q.valid    <= 1'b0;
        out_q.misalign <= 1'b0;
      end
      case (state_q)
        REQ: begin
          if (misaligned) begin
            if (slot_free) begin
              out_q   <= '{valid: 1'b1, raw_instr: 32'h0, pc: pc_q, misalign: 1'b1};
              state_q <= HALT;
            end
          end else if (iresp_data_ok) begin
            pc_q <= pc_q + 64'(INSTR_BYTES);
            if (slot_free) begin
              out_q <= fetched;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            out_q   <= buf_data;
            state_q <= REQ;
          end
        end
        DROP: begin
          if (iresp_data_ok) begin
            state_q <= REQ;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign instr_valid    = out_q.valid;
  assign raw_instr      = out_q.raw_instr;
  assign pc             = out_q.pc;
  assign instr_misalign = out_q.misalign;

endmodule

// File: tb/tb_ifetch_issue.sv
// Self-checking bench for ifetch_issue: a latency-randomised ibus responder plus a
// transaction-level model of the expected request addresses and instruction stream.
module tb_ifetch_issue;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] raw_instr;
  logic [63:0] pc;
  logic        instr_misalign;

  ifetch_issue #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .raw_instr     (raw_instr),
    .pc            (pc),
    .instr_misalign(instr_misalign)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failures  = 0;

  // Reference model: next address the fetch stream should deliver, next address the
  // bus should be asked for, and whether the outstanding bus transaction is stale.
  logic [63:0] exp_pc, req_exp, pend_addr;
  logic        halted, stale, bus_pending, prev_hold;
  logic [63:0] prev_pc;
  logic [31:0] prev_raw;
  logic        prev_mis;
  int          wait_cnt, lat, lat_force, idle, delivered;
  logic [63:0] old_addr;

  function automatic logic [31:0] word_for(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[63:48]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: checks the current cycle, drives inputs for the next rising edge
  task automatic applyStimulus(input logic st, input logic rv, input logic [63:0] rpc);
    logic dok;
    logic exp_mis;
    if (prev_hold) begin
      checkOutput("frozen_pc", pc, prev_pc);
      checkOutput("frozen_word", {instr_valid, instr_misalign, raw_instr},
                  {1'b1, prev_mis, prev_raw});
    end
    if (bus_pending) begin
      checkOutput("req_held_valid", ireq_valid, 1);
      checkOutput("req_held_addr", ireq_addr, pend_addr);
    end else if (ireq_valid) begin
      checkOutput("req_addr", ireq_addr, req_exp);
      checkOutput("req_aligned", ireq_addr[1:0], 0);
      pend_addr = ireq_addr;
      wait_cnt  = 0;
      lat       = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
      idle      = 0;
    end
    if (instr_valid && !st && !rv) begin
      if (halted) begin
        checkOutput("valid_after_halt", instr_valid, 0);
      end else begin
        exp_mis = exp_pc[1:0] != 2'b00;
        checkOutput("out_pc", pc, exp_pc);
        checkOutput("out_word", {instr_misalign, raw_instr},
                    {exp_mis, exp_mis ? 32'h0 : word_for(exp_pc)});
        if (exp_mis) halted = 1'b1;
        else exp_pc = exp_pc + 64'd4;
        delivered++;
        idle = 0;
      end
    end
    if (halted) idle = 0;
    checkOutput("progress", idle < 200, 1);
    if (idle >= 200) idle = 0;

    dok = ireq_valid && (wait_cnt >= lat);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_data_ok  = dok;
    iresp_data     = dok ? word_for(ireq_addr) : $urandom;
    wait_cnt++;

    if (dok) begin
      if (!stale && !rv) req_exp = req_exp + 64'd4;
      stale = 1'b0;
    end
    if (rv) begin
      stale   = ireq_valid && !dok;
      req_exp = rpc;
      exp_pc  = rpc;
      halted  = 1'b0;
    end
    bus_pending = ireq_valid && !dok;
    prev_hold   = instr_valid && st && !rv;
    prev_pc     = pc;
    prev_raw    = raw_instr;
    prev_mis    = instr_misalign;
    idle++;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    @(negedge clk);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_raw", raw_instr, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_misalign", instr_misalign, 0);
    checkOutput("rst_ireq_valid", ireq_valid, 1);
    checkOutput("rst_ireq_addr", ireq_addr, RESET_PC);
    reset       = 1'b0;
    exp_pc      = RESET_PC;
    req_exp     = RESET_PC;
    halted      = 1'b0;
    stale       = 1'b0;
    bus_pending = 1'b0;
    prev_hold   = 1'b0;
    idle        = 0;
  endtask

  initial begin
    logic        st, rv;
    logic [63:0] rpc;
    int          sel;
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    lat_force      = -1;
    delivered      = 0;
    wait_cnt       = 0;
    lat            = 0;
    @(negedge clk);
    doReset();

    // Sequential fetch with a fixed two-cycle bus latency
    lat_force = 2;
    repeat (14) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("t1_delivered", delivered >= 3, 1);

    // Long stall while a response lands: buffered, no further request, then released
    lat_force = 1;
    for (int i = 0; i < 20 && !instr_valid; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("t2_have_valid", instr_valid, 1);
    repeat (5) applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("t2_hold_noreq", ireq_valid, 0);
    checkOutput("t2_still_valid", instr_valid, 1);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("t2_buf_out", instr_valid, 1);
    repeat (6) applyStimulus(1'b0, 1'b0, 64'h0);

    // Redirect while a request is outstanding: address held, next request at target
    lat_force = 3;
    for (int i = 0; i < 20 && !(ireq_valid && !bus_pending); i++)
      applyStimulus(1'b0, 1'b0, 64'h0);
    old_addr = ireq_addr;
    applyStimulus(1'b0, 1'b1, 64'h8000_1000);
    checkOutput("t3_drop_hold", ireq_addr, old_addr);
    for (int i = 0; i < 20 && !(ireq_valid && !bus_pending); i++)
      applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("t3_new_req", ireq_addr, 64'h8000_1000);

    // Redirect in the same cycle as data_ok
    lat_force = 0;
    for (int i = 0; i < 20 && !ireq_valid; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'h8000_2000);
    checkOutput("t4_valid", instr_valid, 0);
    checkOutput("t4_req_valid", ireq_valid, 1);
    checkOutput("t4_req_addr", ireq_addr, 64'h8000_2000);

    // Misaligned redirect target halts fetch until the next redirect
    lat_force = -1;
    applyStimulus(1'b0, 1'b1, 64'h8000_0002);
    for (int i = 0; i < 20 && !instr_valid; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("t5_valid", instr_valid, 1);
    checkOutput("t5_misalign", instr_misalign, 1);
    checkOutput("t5_raw", raw_instr, 0);
    checkOutput("t5_pc", pc, 64'h8000_0002);
    repeat (8) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("t5_halt_ireq", ireq_valid, 0);
    checkOutput("t5_halt_valid", instr_valid, 0);
    applyStimulus(1'b0, 1'b1, RESET_PC);
    checkOutput("t5_resume_valid", ireq_valid, 1);
    checkOutput("t5_resume_addr", ireq_addr, RESET_PC);

    // Reset while a request is waiting for its response
    lat_force = 5;
    for (int i = 0; i < 10 && !ireq_valid; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0);
    doReset();
    lat_force = -1;

    // Random stall/redirect traffic, including misaligned and wrap-around targets
    delivered = 0;
    repeat (1500) begin
      st  = ($urandom % 3) == 0;
      rv  = ($urandom % 40) == 0;
      sel = $urandom % 8;
      if (sel == 0) rpc = 64'h8000_3000 + 64'($urandom_range(1, 3));
      else if (sel == 1) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      else rpc = RESET_PC + 64'($urandom_range(0, 1023) * 4);
      applyStimulus(st, rv, rpc);
    end
    checkOutput("rand_delivered", delivered > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
